// File: rtl/isp_pkg.sv
// isp_pkg: Bayer pattern, frame-sequencer state and config types shared by the ISP front end
package isp_pkg;
    typedef enum logic [1:0] {BAYER_RGGB, BAYER_GRBG, BAYER_GBRG, BAYER_BGGR} bayer_e;
    typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_FLUSH_GAP, ST_FLUSH_LINE} state_e;
    typedef struct packed {
        bayer_e bayer;
        logic   enable;
    } cfg_t;
endpackage

// File: rtl/isp_edge_det.sv
// isp_edge_det: single-cycle rise/fall pulses for a level input, aligned with the input cycle
module isp_edge_det (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);
    logic d_q;
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) d_q <= 1'b0;
        else d_q <= d_i;
    end
    assign rise_o = d_i && !d_q;
    assign fall_o = !d_i && d_q;
endmodule

// File: rtl/isp_demosaic_ctrl.sv
// isp_demosaic_ctrl: frame sequencer with shadowed Bayer config and synthetic end-of-frame flush lines
module isp_demosaic_ctrl
    import isp_pkg::*;
#(
    parameter int BITS        = 8,
    parameter int WIDTH       = 1280,
    parameter int HEIGHT      = 960,
    parameter int FLUSH_LINES = 3,
    parameter int HBLANK      = 64
) (
    input  logic            pclk_i,
    input  logic            rst_n_i,
    input  logic            cfg_we_i,
    input  logic [1:0]      cfg_bayer_i,
    input  logic            cfg_enable_i,
    input  logic            err_clr_i,
    input  logic            in_href_i,
    input  logic            in_vsync_i,
    input  logic [BITS-1:0] in_raw_i,
    output logic            out_href_o,
    output logic            out_vsync_o,
    output logic [BITS-1:0] out_raw_o,
    output logic [1:0]      act_bayer_o,
    output logic            act_enable_o,
    output logic            busy_o,
    output logic            frame_done_o,
    output logic            err_len_o,
    output logic            err_frame_o
);
    localparam int PW = $clog2(WIDTH + 1);
    localparam int LW = $clog2(HEIGHT + 1);
    localparam int CW = $clog2((WIDTH > HBLANK ? WIDTH : HBLANK) + 1);
    localparam int FW = $clog2(FLUSH_LINES + 1);

    state_e          state_q, state_d;
    cfg_t            pend_q, pend_d, act_q, act_d;
    logic [PW-1:0]   pix_q, pix_d;
    logic [LW-1:0]   line_q, line_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [FW-1:0]   flush_q, flush_d;
    logic [BITS-1:0] raw_q, raw_d;
    logic            href_q, href_d, vsync_q, done_q, done_d;
    logic            err_len_q, err_len_d, err_frame_q, err_frame_d;
    logic            href_rise, href_fall, vs_rise, vs_fall, flushing, len_bad, frame_bad;

    isp_edge_det u_href_edge (
        .clk_i(pclk_i), .rst_n_i(rst_n_i), .d_i(in_href_i), .rise_o(href_rise), .fall_o(href_fall)
    );
    isp_edge_det u_vsync_edge (
        .clk_i(pclk_i), .rst_n_i(rst_n_i), .d_i(in_vsync_i), .rise_o(vs_rise), .fall_o(vs_fall)
    );

    assign flushing  = (state_q == ST_FLUSH_GAP) || (state_q == ST_FLUSH_LINE);
    assign len_bad   = href_fall && (pix_q != PW'(WIDTH));
    assign frame_bad = (flushing && (in_href_i || vs_rise)) ||
                       ((state_q == ST_ACTIVE) && vs_rise && (line_q < LW'(HEIGHT)));

    always_comb begin
        pend_d      = cfg_we_i ? '{bayer: bayer_e'(cfg_bayer_i), enable: cfg_enable_i} : pend_q;
        act_d       = vs_rise ? pend_d : act_q;
        pix_d       = (vs_rise || href_fall) ? '0 :
                      href_rise ? PW'(1) :
                      (in_href_i && pix_q != '1) ? pix_q + PW'(1) : pix_q;
        line_d      = vs_rise ? '0 : (href_fall && line_q != '1) ? line_q + LW'(1) : line_q;
        err_len_d   = len_bad || (err_len_q && !err_clr_i);
        err_frame_d = frame_bad || (err_frame_q && !err_clr_i);
        state_d     = state_q;
        cnt_d       = cnt_q;
        flush_d     = flush_q;
        done_d      = 1'b0;
        href_d      = in_href_i;
        raw_d       = in_href_i ? in_raw_i : '0;
        case (state_q)
            ST_IDLE: if (vs_fall) state_d = ST_ACTIVE;
            ST_ACTIVE: begin
                if (vs_rise) state_d = ST_IDLE;
                else if (href_fall && line_d == LW'(HEIGHT)) begin
                    state_d = ST_FLUSH_GAP;
                    cnt_d   = '0;
                    flush_d = '0;
                end
            end
            ST_FLUSH_GAP: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(HBLANK - 1)) begin
                    state_d = ST_FLUSH_LINE;
                    cnt_d   = '0;
                end
            end
            ST_FLUSH_LINE: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    cnt_d   = '0;
                    flush_d = flush_q + FW'(1);
                    state_d = (flush_d == FW'(FLUSH_LINES)) ? ST_IDLE : ST_FLUSH_GAP;
                    done_d  = (flush_d == FW'(FLUSH_LINES));
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // sensor pixels are dropped while flushing; a new vsync aborts the synthetic line
        if (flushing) begin
            href_d = (state_q == ST_FLUSH_LINE) && !vs_rise;
            raw_d  = '0;
            if (vs_rise) begin
                state_d = ST_IDLE;
                done_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge pclk_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            pend_q      <= '0;
            act_q       <= '0;
            pix_q       <= '0;
            line_q      <= '0;
            cnt_q       <= '0;
            flush_q     <= '0;
            raw_q       <= '0;
            href_q      <= 1'b0;
            vsync_q     <= 1'b0;
            done_q      <= 1'b0;
            err_len_q   <= 1'b0;
            err_frame_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            act_q       <= act_d;
            pix_q       <= pix_d;
            line_q      <= line_d;
            cnt_q       <= cnt_d;
            flush_q     <= flush_d;
            raw_q       <= raw_d;
            href_q      <= href_d;
            vsync_q     <= in_vsync_i;
            done_q      <= done_d;
            err_len_q   <= err_len_d;
            err_frame_q <= err_frame_d;
        end
    end

    assign out_href_o   = href_q;
    assign out_vsync_o  = vsync_q;
    assign out_raw_o    = raw_q;
    assign act_bayer_o  = act_q.bayer;
    assign act_enable_o = act_q.enable;
    assign busy_o       = state_q != ST_IDLE;
    assign frame_done_o = done_q;
    assign err_len_o    = err_len_q;
    assign err_frame_o  = err_frame_q;
endmodule

// File: tb/tb_isp_demosaic_ctrl.sv
// tb_isp_demosaic_ctrl: randomized frames against a line-level scoreboard and a config/error model
module tb_isp_demosaic_ctrl;
    localparam int BITS = 8;
    localparam int W    = 8;
    localparam int H    = 4;
    localparam int FL   = 3;
    localparam int HB   = 4;

    typedef struct packed {
        logic [BITS-1:0] raw;
        logic            sol;
        logic            chk;
        logic [7:0]      gap;
    } beat_t;

    logic clk = 1'b0, rst_n = 1'b0, cfg_we = 1'b0, cfg_enable = 1'b0, err_clr = 1'b0;
    logic in_href = 1'b0, in_vsync = 1'b0;
    logic [1:0] cfg_bayer = 2'd0;
    logic [BITS-1:0] in_raw = '0;
    logic out_href, out_vsync, act_enable, busy, frame_done, err_len, err_frame;
    logic [BITS-1:0] out_raw;
    logic [1:0] act_bayer;

    beat_t exp_q[$];
    beat_t mon_b;
    int vectors = 0, errors = 0, done_cnt = 0, exp_done = 0, low_run = 0;
    logic prev_href = 1'b0, exp_vs = 1'b0;
    logic [1:0] m_pend_b = 2'd0, m_act_b = 2'd0;
    logic m_pend_e = 1'b0, m_act_e = 1'b0, m_len = 1'b0, m_frame = 1'b0;

    always #5 clk = ~clk;

    isp_demosaic_ctrl #(.BITS(BITS), .WIDTH(W), .HEIGHT(H), .FLUSH_LINES(FL), .HBLANK(HB)) dut (
        .pclk_i(clk), .rst_n_i(rst_n), .cfg_we_i(cfg_we), .cfg_bayer_i(cfg_bayer),
        .cfg_enable_i(cfg_enable), .err_clr_i(err_clr), .in_href_i(in_href), .in_vsync_i(in_vsync),
        .in_raw_i(in_raw), .out_href_o(out_href), .out_vsync_o(out_vsync), .out_raw_o(out_raw),
        .act_bayer_o(act_bayer), .act_enable_o(act_enable), .busy_o(busy),
        .frame_done_o(frame_done), .err_len_o(err_len), .err_frame_o(err_frame)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    function automatic beat_t mk(input logic [BITS-1:0] raw, input logic sol, input logic chk, input int gap);
        beat_t b;
        b.raw = raw;
        b.sol = sol;
        b.chk = chk;
        b.gap = 8'(gap);
        return b;
    endfunction

    always @(posedge clk) exp_vs <= rst_n ? in_vsync : 1'b0;

    always @(negedge clk) begin
        check("out_vsync", out_vsync, exp_vs);
        if (!out_href) begin
            check("raw_when_idle", out_raw, 0);
            low_run++;
        end else begin
            if (exp_q.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected_beat: got raw %0d expected no beat", out_raw);
            end else begin
                mon_b = exp_q.pop_front();
                check("raw", out_raw, mon_b.raw);
                check("line_start", !prev_href, mon_b.sol);
                if (mon_b.sol && mon_b.chk) check("flush_gap", low_run, mon_b.gap);
            end
            low_run = 0;
        end
        if (frame_done) done_cnt++;
        prev_href = out_href;
    end

    task automatic cyc(input logic h, input logic v, input logic [BITS-1:0] r);
        in_href  = h;
        in_vsync = v;
        in_raw   = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, in_vsync, '0);
    endtask

    task automatic vs_rise();
        if (cfg_we) begin
            m_pend_b = cfg_bayer;
            m_pend_e = cfg_enable;
        end
        m_act_b = m_pend_b;
        m_act_e = m_pend_e;
        cyc(1'b0, 1'b1, '0);
        cfg_we = 1'b0;
        cyc(1'b0, 1'b1, '0);
    endtask

    task automatic line(input int len, input int ln, input bit rnd, input bit clr);
        for (int p = 0; p < len; p++) begin
            logic [BITS-1:0] r = rnd ? BITS'($urandom) : BITS'(ln * 16 + p);
            exp_q.push_back(mk(r, p == 0, 1'b0, 0));
            cyc(1'b1, 1'b0, r);
        end
        m_len   = (len != W) || (m_len && !clr);
        m_frame = m_frame && !clr;
        err_clr = clr;
        cyc(1'b0, 1'b0, '0);
        err_clr = 1'b0;
    endtask

    task automatic frame(input int nlines, input int short_idx, input bit rnd, input bit clr_short, input int cfg_line);
        if (!in_vsync) vs_rise();
        repeat (3) cyc(1'b0, 1'b0, '0);
        for (int l = 0; l < nlines; l++) begin
            line(l == short_idx ? W - 1 : W, l, rnd, clr_short && l == short_idx);
            if (l == cfg_line) begin
                cfg_we     = 1'b1;
                cfg_bayer  = 2'd3;
                cfg_enable = 1'b0;
                m_pend_b   = 2'd3;
                m_pend_e   = 1'b0;
                cyc(1'b0, 1'b0, '0);
                cfg_we = 1'b0;
            end
            if (l != nlines - 1) idle(5);
        end
    endtask

    task automatic push_flush();
        for (int l = 0; l < FL; l++)
            for (int p = 0; p < W; p++)
                exp_q.push_back(mk('0, p == 0, 1'b1, l == 0 ? HB + 1 : HB));
        exp_done++;
    endtask

    task automatic clear();
        err_clr = 1'b1;
        cyc(1'b0, in_vsync, '0);
        err_clr = 1'b0;
        m_len   = 1'b0;
        m_frame = 1'b0;
        check("err_len_cleared", err_len, 0);
        check("err_frame_cleared", err_frame, 0);
    endtask

    task automatic chk_state(input string t);
        check({t, "_err_len"}, err_len, m_len);
        check({t, "_err_frame"}, err_frame, m_frame);
        check({t, "_frame_done_count"}, done_cnt, exp_done);
        check({t, "_busy"}, busy, 0);
        check({t, "_act_bayer"}, act_bayer, m_act_b);
        check({t, "_act_enable"}, act_enable, m_act_e);
        check({t, "_pending_beats"}, exp_q.size(), 0);
    endtask

    task automatic chk_reset(input string t);
        check({t, "_out_href"}, out_href, 0);
        check({t, "_out_vsync"}, out_vsync, 0);
        check({t, "_out_raw"}, out_raw, 0);
        check({t, "_act_bayer"}, act_bayer, 0);
        check({t, "_act_enable"}, act_enable, 0);
        check({t, "_busy"}, busy, 0);
        check({t, "_frame_done"}, frame_done, 0);
        check({t, "_err_len"}, err_len, 0);
        check({t, "_err_frame"}, err_frame, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_reset("reset");
        rst_n = 1'b1;
        // nominal frame, config staged before the frame and rewritten mid-frame
        cfg_we = 1'b1;
        cfg_bayer = 2'd2;
        cfg_enable = 1'b1;
        m_pend_b = 2'd2;
        m_pend_e = 1'b1;
        cyc(1'b0, 1'b0, '0);
        cfg_we = 1'b0;
        frame(H, -1, 1'b0, 1'b0, 1);
        push_flush();
        idle(FL * (W + HB) + 10);
        chk_state("nominal");
        // config written on the vsync-rise cycle, short line 2
        cfg_we = 1'b1;
        cfg_bayer = 2'd1;
        cfg_enable = 1'b1;
        frame(H, 2, 1'b1, 1'b0, -1);
        push_flush();
        idle(FL * (W + HB) + 10);
        chk_state("short_line");
        clear();
        // err_clr coincident with a bad line end
        frame(H, 1, 1'b1, 1'b1, -1);
        push_flush();
        idle(FL * (W + HB) + 10);
        chk_state("clr_vs_set");
        clear();
        // sensor href intrudes during the second synthetic line
        frame(H, -1, 1'b1, 1'b0, -1);
        push_flush();
        idle(2 * HB + W + 2);
        check("busy_in_flush", busy, 1);
        m_frame = 1'b1;
        m_len = 1'b1;
        repeat (3) cyc(1'b1, 1'b0, BITS'($urandom_range(1, 255)));
        cyc(1'b0, 1'b0, '0);
        idle(FL * (W + HB));
        chk_state("intrusion");
        clear();
        // vsync arrives inside the first flush gap
        frame(H, -1, 1'b1, 1'b0, -1);
        idle(2);
        m_frame = 1'b1;
        vs_rise();
        idle(FL * (W + HB) + 10);
        chk_state("gap_abort");
        clear();
        // frame cut short after three lines
        frame(H - 1, -1, 1'b1, 1'b0, -1);
        idle(5);
        m_frame = 1'b1;
        vs_rise();
        idle(FL * (W + HB) + 10);
        chk_state("short_frame");
        clear();
        // reset mid-frame, then a clean frame
        frame(2, 1, 1'b1, 1'b0, -1);
        idle(3);
        check("pre_reset_err_len", err_len, 1);
        check("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        cyc(1'b0, 1'b0, '0);
        rst_n = 1'b1;
        chk_reset("mid_reset");
        m_pend_b = 2'd0;
        m_pend_e = 1'b0;
        m_act_b = 2'd0;
        m_act_e = 1'b0;
        m_len = 1'b0;
        m_frame = 1'b0;
        idle(3);
        frame(H, -1, 1'b1, 1'b0, -1);
        push_flush();
        idle(FL * (W + HB) + 10);
        chk_state("after_reset");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
